// File: rtl/vt52_cmd_writer_if.sv
// vt52_cmd_writer_if: byte-stream handshake from the host plus the
// char_buffer write port and cursor position driven by vt52_cmd_writer.
interface vt52_cmd_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] buf_addr;
    logic [7:0]  buf_din;
    logic        buf_wen;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    // Host / upstream side: supplies bytes, observes the writer
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  buf_addr,
        input  buf_din,
        input  buf_wen,
        input  cursor_row,
        input  cursor_col
    );

    // Writer side: consumes bytes, drives the buffer port and cursor
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output buf_addr,
        output buf_din,
        output buf_wen,
        output cursor_row,
        output cursor_col
    );
endinterface

// File: rtl/vt52_cmd_writer.sv
// vt52_cmd_writer: decodes a VT52 subset from a byte stream into
// single-cycle char_buffer writes and tracks the cursor.
// Optional feature: define VT52_DIRECT_ADDR_EN to enable ESC Y row col
// direct cursor addressing.
module vt52_cmd_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 24,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic               pclk,
    input  logic               clr,
    vt52_cmd_writer_if.slave   bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ESC      = 3'd1;
`ifdef VT52_DIRECT_ADDR_EN
    localparam logic [2:0] S_ESCY_ROW = 3'd2;
    localparam logic [2:0] S_ESCY_COL = 3'd3;
`endif
    localparam logic [2:0] S_CLEAR    = 3'd4;

    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [10:0] LAST_ADDR = 11'(COLS * ROWS - 1);

    logic [2:0]  r_state;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [10:0] r_addr;
    logic [7:0]  r_din;
    logic        r_wen;
    logic [10:0] r_clrEnd;

    logic        w_accept;
    logic        w_printable;
    logic [10:0] w_curAddr;
    logic [10:0] w_rowEnd;
    logic [7:0]  w_tabSum;
    logic [6:0]  w_tabCol;

`ifdef VT52_DIRECT_ADDR_EN
    logic [4:0]  r_yRow;
    logic [7:0]  w_yVal;
    logic [4:0]  w_yRow;
    logic [6:0]  w_yCol;
`endif

    // Handshake: stall the host only while a clear sweep is running
    assign bus.in_ready = (r_state != S_CLEAR);
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.buf_addr   = r_addr;
    assign bus.buf_din    = r_din;
    assign bus.buf_wen    = r_wen;
    assign bus.cursor_row = r_row;
    assign bus.cursor_col = r_col;

    // Cursor-derived addresses and the saturating tab-stop column
    always_comb begin
        w_printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
        w_curAddr   = 11'(r_row) * 11'(COLS) + 11'(r_col);
        w_rowEnd    = 11'(r_row) * 11'(COLS) + 11'(LAST_COL);
        w_tabSum    = {1'b0, (r_col | 7'd7)} + 8'd1;
        w_tabCol    = (w_tabSum > {1'b0, LAST_COL}) ? LAST_COL : w_tabSum[6:0];
    end

`ifdef VT52_DIRECT_ADDR_EN
    // ESC Y coordinate bytes are offset by 0x20 and clamped to the screen
    always_comb begin
        w_yVal = (bus.in_data < 8'h20) ? 8'h00 : (bus.in_data - 8'h20);
        w_yRow = (w_yVal > {3'b000, LAST_ROW}) ? LAST_ROW : w_yVal[4:0];
        w_yCol = (w_yVal > {1'b0, LAST_COL}) ? LAST_COL : w_yVal[6:0];
    end
`endif

    // Decoder state machine, cursor update and buffer write generation
    always_ff @(posedge pclk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_wen    <= 1'b0;
            r_clrEnd <= '0;
`ifdef VT52_DIRECT_ADDR_EN
            r_yRow   <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_wen  <= 1'b1;
                            r_addr <= w_curAddr;
                            r_din  <= bus.in_data;
                            if (r_col < LAST_COL) r_col <= r_col + 7'd1;
                        end else begin
                            case (bus.in_data)
                                8'h0D: r_col <= '0;
                                8'h08: if (r_col != '0) r_col <= r_col - 7'd1;
                                8'h09: r_col <= w_tabCol;
                                8'h0A: begin
                                    if (r_row < LAST_ROW) begin
                                        r_row <= r_row + 5'd1;
                                    end else begin
                                        r_row    <= '0;
                                        r_wen    <= 1'b1;
                                        r_addr   <= '0;
                                        r_din    <= FILL_CHAR;
                                        r_clrEnd <= 11'(LAST_COL);
                                        r_state  <= S_CLEAR;
                                    end
                                end
                                8'h1B: r_state <= S_ESC;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ESC: begin
                    if (w_accept) begin
                        r_state <= S_IDLE;
                        case (bus.in_data)
                            8'h41: if (r_row != '0) r_row <= r_row - 5'd1;
                            8'h42: if (r_row < LAST_ROW) r_row <= r_row + 5'd1;
                            8'h43: if (r_col < LAST_COL) r_col <= r_col + 7'd1;
                            8'h44: if (r_col != '0) r_col <= r_col - 7'd1;
                            8'h48: begin
                                r_row <= '0;
                                r_col <= '0;
                            end
                            8'h4A: begin
                                r_wen    <= 1'b1;
                                r_addr   <= w_curAddr;
                                r_din    <= FILL_CHAR;
                                r_clrEnd <= LAST_ADDR;
                                r_state  <= S_CLEAR;
                            end
                            8'h4B: begin
                                r_wen    <= 1'b1;
                                r_addr   <= w_curAddr;
                                r_din    <= FILL_CHAR;
                                r_clrEnd <= w_rowEnd;
                                r_state  <= S_CLEAR;
                            end
`ifdef VT52_DIRECT_ADDR_EN
                            8'h59: r_state <= S_ESCY_ROW;
`endif
                            default: ;
                        endcase
                    end
                end
`ifdef VT52_DIRECT_ADDR_EN
                S_ESCY_ROW: begin
                    if (w_accept) begin
                        r_yRow  <= w_yRow;
                        r_state <= S_ESCY_COL;
                    end
                end
                S_ESCY_COL: begin
                    if (w_accept) begin
                        r_row   <= r_yRow;
                        r_col   <= w_yCol;
                        r_state <= S_IDLE;
                    end
                end
`endif
                S_CLEAR: begin
                    if (r_addr == r_clrEnd) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_addr <= r_addr + 11'd1;
                        r_wen  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vt52_cmd_writer.sv
// tb_vt52_cmd_writer: self-checking bench for vt52_cmd_writer.
// Honours VT52_DIRECT_ADDR_EN the same way as the design.
module tb_vt52_cmd_writer;

    logic pclk = 1'b0;
    logic clr  = 1'b1;

    vt52_cmd_writer_if bus();

    vt52_cmd_writer #(.COLS(80), .ROWS(24), .FILL_CHAR(8'h20)) dut (
        .pclk (pclk),
        .clr  (clr),
        .bus  (bus)
    );

    // Free-running pixel clock
    always #5 pclk = ~pclk;

    typedef struct {
        int addr;
        int data;
    } write_t;

    typedef struct {
        logic [7:0] b;
        int         expRow;
        int         expCol;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    int     mRow = 0;
    int     mCol = 0;
    int     mMode = 0;
    int     mYRow = 0;
    int     clearRemaining = 0;
    write_t expQ[$];

    vec_t vecs[26];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRow = 0;
        mCol = 0;
        mMode = 0;
        mYRow = 0;
        clearRemaining = 0;
        expQ.delete();
    endtask

    task automatic modelClear(input int first, input int last);
        for (int a = first; a <= last; a++) expQ.push_back('{a, 32});
        clearRemaining = last - first + 1;
    endtask

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Terminal behaviour expressed on plain screen coordinates
    task automatic modelByte(input int b);
        case (mMode)
            0: begin
                if (b >= 32 && b <= 126) begin
                    expQ.push_back('{mRow * 80 + mCol, b});
                    mCol = clampInt(mCol + 1, 0, 79);
                end else if (b == 13) mCol = 0;
                else if (b == 8) mCol = clampInt(mCol - 1, 0, 79);
                else if (b == 9) mCol = clampInt((mCol / 8 + 1) * 8, 0, 79);
                else if (b == 10) begin
                    if (mRow == 23) begin
                        mRow = 0;
                        modelClear(0, 79);
                    end else mRow = mRow + 1;
                end else if (b == 27) mMode = 1;
            end
            1: begin
                mMode = 0;
                case (b)
                    65: mRow = clampInt(mRow - 1, 0, 23);
                    66: mRow = clampInt(mRow + 1, 0, 23);
                    67: mCol = clampInt(mCol + 1, 0, 79);
                    68: mCol = clampInt(mCol - 1, 0, 79);
                    72: begin mRow = 0; mCol = 0; end
                    74: modelClear(mRow * 80 + mCol, 1919);
                    75: modelClear(mRow * 80 + mCol, mRow * 80 + 79);
`ifdef VT52_DIRECT_ADDR_EN
                    89: mMode = 2;
`endif
                    default: ;
                endcase
            end
            2: begin
                mYRow = (b < 32) ? 0 : clampInt(b - 32, 0, 23);
                mMode = 3;
            end
            default: begin
                mRow = mYRow;
                mCol = (b < 32) ? 0 : clampInt(b - 32, 0, 79);
                mMode = 0;
            end
        endcase
    endtask

    // Drive one byte starting at a falling edge; returns at the falling edge after the transfer
    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 4000) begin
            @(negedge pclk);
            guard++;
        end
        if (guard >= 4000) begin
            checkOutput("ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge pclk);
        modelByte(int'(b));
        @(negedge pclk);
        bus.in_valid = 1'b0;
    endtask

    task automatic countLowCycles(output int n);
        n = 0;
        while (!bus.in_ready && n < 5000) begin
            n++;
            @(negedge pclk);
        end
    endtask

    task automatic goHome();
        applyStimulus(8'h1B);
        applyStimulus(8'h48);
    endtask

    // Per-cycle comparison of handshake, cursor and every buffer write
    always @(negedge pclk) begin
        if (chkEn && !clr) begin
            checkOutput("in_ready", int'(bus.in_ready), (clearRemaining == 0) ? 1 : 0);
            checkOutput("cursor_row", int'(bus.cursor_row), mRow);
            checkOutput("cursor_col", int'(bus.cursor_col), mCol);
            if (bus.buf_wen) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    write_t w;
                    w = expQ.pop_front();
                    checkOutput("buf_addr", int'(bus.buf_addr), w.addr);
                    checkOutput("buf_din", int'(bus.buf_din), w.data);
                    if (clearRemaining > 0) clearRemaining--;
                end
            end
        end
    end

    function automatic logic [7:0] randByte();
        int r;
        int k;
        r = $urandom_range(0, 15);
        case (r)
            0, 1, 2, 3, 4, 5: return 8'($urandom_range(32, 126));
            6:  return 8'h0D;
            7:  return 8'h08;
            8:  return 8'h09;
            9:  return 8'h0A;
            10, 11: return 8'h1B;
            12: return 8'($urandom_range(65, 68));
            13: begin
                k = $urandom_range(0, 3);
                case (k)
                    0: return 8'h48;
                    1: return 8'h4A;
                    2: return 8'h4B;
                    default: return 8'h59;
                endcase
            end
            14: return 8'($urandom_range(32, 127));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int n;

        vecs[0]  = '{8'h41, 0, 1};
        vecs[1]  = '{8'h1B, 0, 1};
        vecs[2]  = '{8'h42, 1, 1};
        vecs[3]  = '{8'h1B, 1, 1};
        vecs[4]  = '{8'h42, 2, 1};
        vecs[5]  = '{8'h09, 2, 8};
        vecs[6]  = '{8'h08, 2, 7};
        vecs[7]  = '{8'h0D, 2, 0};
        vecs[8]  = '{8'h0A, 3, 0};
        vecs[9]  = '{8'h1B, 3, 0};
        vecs[10] = '{8'h43, 3, 1};
        vecs[11] = '{8'h1B, 3, 1};
        vecs[12] = '{8'h1B, 3, 1};
        vecs[13] = '{8'h43, 3, 2};
        vecs[14] = '{8'h07, 3, 2};
        vecs[15] = '{8'h1B, 3, 2};
        vecs[16] = '{8'h48, 0, 0};
        vecs[17] = '{8'h1B, 0, 0};
        vecs[18] = '{8'h44, 0, 0};
        vecs[19] = '{8'h7E, 0, 1};
        vecs[20] = '{8'h7F, 0, 1};
        vecs[21] = '{8'h1B, 0, 1};
        vecs[22] = '{8'h41, 0, 1};
        vecs[23] = '{8'h1B, 0, 1};
        vecs[24] = '{8'h5A, 0, 1};
        vecs[25] = '{8'h5A, 0, 2};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset values while clr is held
        repeat (3) @(negedge pclk);
        checkOutput("rst_wen", int'(bus.buf_wen), 0);
        checkOutput("rst_addr", int'(bus.buf_addr), 0);
        checkOutput("rst_din", int'(bus.buf_din), 0);
        checkOutput("rst_row", int'(bus.cursor_row), 0);
        checkOutput("rst_col", int'(bus.cursor_col), 0);
        #2 clr = 1'b0;
        @(negedge pclk);
        checkOutput("rst_ready", int'(bus.in_ready), 1);
        modelReset();
        chkEn = 1'b1;

        // Directed vectors from reset
        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].b);
            checkOutput($sformatf("vec%0d_row", i), int'(bus.cursor_row), vecs[i].expRow);
            checkOutput($sformatf("vec%0d_col", i), int'(bus.cursor_col), vecs[i].expCol);
        end

        // Bottom-row LF: wrap to row 0 and clear it
        goHome();
        for (int i = 0; i < 10; i++) begin applyStimulus(8'h1B); applyStimulus(8'h43); end
        for (int i = 0; i < 23; i++) begin applyStimulus(8'h1B); applyStimulus(8'h42); end
        checkOutput("pre_lf_row", int'(bus.cursor_row), 23);
        checkOutput("pre_lf_col", int'(bus.cursor_col), 10);
        applyStimulus(8'h0A);
        checkOutput("lf_wrap_row", int'(bus.cursor_row), 0);
        checkOutput("lf_wrap_col", int'(bus.cursor_col), 10);
        countLowCycles(n);
        checkOutput("lf_clear_cycles", n, 80);

        // ESC K from (23,70)
        goHome();
        for (int i = 0; i < 23; i++) begin applyStimulus(8'h1B); applyStimulus(8'h42); end
        for (int i = 0; i < 70; i++) begin applyStimulus(8'h1B); applyStimulus(8'h43); end
        applyStimulus(8'h1B);
        applyStimulus(8'h4B);
        countLowCycles(n);
        checkOutput("esck_cycles", n, 10);
        checkOutput("esck_row", int'(bus.cursor_row), 23);
        checkOutput("esck_col", int'(bus.cursor_col), 70);

        // ESC J at the last cell: a single write
        for (int i = 0; i < 10; i++) applyStimulus(8'h09);
        checkOutput("tab_cap_col", int'(bus.cursor_col), 79);
        applyStimulus(8'h1B);
        applyStimulus(8'h4A);
        countLowCycles(n);
        checkOutput("escj_last_cycles", n, 1);

        // Right margin: no autowrap, then backspace saturation
        goHome();
        for (int i = 0; i < 10; i++) applyStimulus(8'h09);
        applyStimulus(8'h5A);
        applyStimulus(8'h5A);
        checkOutput("margin_col", int'(bus.cursor_col), 79);
        for (int i = 0; i < 100; i++) applyStimulus(8'h08);
        checkOutput("bs_sat_col", int'(bus.cursor_col), 0);

        // ESC Y 0x25 0x7F
        goHome();
        applyStimulus(8'h1B);
        applyStimulus(8'h59);
        applyStimulus(8'h25);
        applyStimulus(8'h7F);
`ifdef VT52_DIRECT_ADDR_EN
        checkOutput("escy_row", int'(bus.cursor_row), 5);
        checkOutput("escy_col", int'(bus.cursor_col), 79);
`else
        checkOutput("escy_row", int'(bus.cursor_row), 0);
        checkOutput("escy_col", int'(bus.cursor_col), 1);
`endif

        // Reset in the middle of a full-screen clear
        goHome();
        applyStimulus(8'h1B);
        applyStimulus(8'h4A);
        repeat (20) @(negedge pclk);
        #2 clr = 1'b1;
        #1;
        checkOutput("midclr_wen", int'(bus.buf_wen), 0);
        checkOutput("midclr_addr", int'(bus.buf_addr), 0);
        checkOutput("midclr_ready", int'(bus.in_ready), 1);
        modelReset();
        @(negedge pclk);
        #2 clr = 1'b0;
        repeat (10) @(negedge pclk);

        // Randomized traffic with idle gaps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge pclk);
            applyStimulus(randByte());
        end

        n = 0;
        while (clearRemaining > 0 && n < 4000) begin
            @(negedge pclk);
            n++;
        end
        repeat (3) @(negedge pclk);
        checkOutput("drain_pending", expQ.size(), 0);
        chkEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
